// File: rtl/sys_defs.sv
// Shared core definitions used by the multiply functional unit:
// default tag widths, ALU function encodings, the per-op packet that
// travels down the multiplier pipe, and the unknown-func fallback value.
package sys_defs;

   // Default widths; the functional unit's parameters should match these
   // because MUL_PACKET is a fixed-layout struct.
   localparam int XLEN_DEF    = 32;
   localparam int PRF_LEN_DEF = 6;
   localparam int ROB_LEN_DEF = 5;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'h00,
      ALU_SUB    = 5'h01,
      ALU_SLT    = 5'h02,
      ALU_SLTU   = 5'h03,
      ALU_AND    = 5'h04,
      ALU_OR     = 5'h05,
      ALU_XOR    = 5'h06,
      ALU_SLL    = 5'h07,
      ALU_SRL    = 5'h08,
      ALU_SRA    = 5'h09,
      ALU_MUL    = 5'h0a,
      ALU_MULH   = 5'h0b,
      ALU_MULHSU = 5'h0c,
      ALU_MULHU  = 5'h0d
   } ALU_FUNC;

   // Returned when a non-multiply func reaches the end of the pipe.
   localparam logic [31:0] MUL_FALLBACK = 32'hfacebeec;

   typedef struct packed {
      logic [XLEN_DEF-1:0]    pc;
      logic [PRF_LEN_DEF-1:0] dest_preg;
      logic [ROB_LEN_DEF-1:0] rob_idx;
      logic                   a_neg;
      logic                   b_neg;
      ALU_FUNC                func;
   } MUL_PACKET;

   // Reset packet: func is MUL so a cleared pipe presents a zero result.
   localparam MUL_PACKET MUL_PACKET_RESET = '{
      pc:        '0,
      dest_preg: '0,
      rob_idx:   '0,
      a_neg:     1'b0,
      b_neg:     1'b0,
      func:      ALU_MUL
   };

endpackage

// File: rtl/mul_pipe_stage.sv
// One multiplier pipe stage: multiplies the multiplicand by the low
// STAGE_BITS of the remaining multiplier, accumulates, and shifts both
// operands for the next stage. Carries a valid bit and the op packet.
// Holds everything while stalled; squash clears only the valid bit.
module mul_pipe_stage
   import sys_defs::*;
#(
   parameter int XLEN       = 32,
   parameter int STAGE_BITS = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              squash,
   input  logic              stall,
   input  logic              prev_valid,
   input  MUL_PACKET         prev_packet,
   input  logic [2*XLEN-1:0] prev_mcand,
   input  logic [2*XLEN-1:0] prev_mplier,
   input  logic [2*XLEN-1:0] prev_product,
   output logic              valid,
   output MUL_PACKET         packet,
   output logic [2*XLEN-1:0] mcand,
   output logic [2*XLEN-1:0] mplier,
   output logic [2*XLEN-1:0] product
);

   localparam int PW = 2 * XLEN;

   logic [PW-1:0] mplier_slice;
   logic [PW-1:0] partial;

   // Partial product of this stage's multiplier digit.
   always_comb begin
      mplier_slice                 = '0;
      mplier_slice[STAGE_BITS-1:0] = prev_mplier[STAGE_BITS-1:0];
      partial                      = prev_mcand * mplier_slice;
   end

   // Stage register: reset clears all, squash kills valid, stall holds.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid   <= 1'b0;
         packet  <= MUL_PACKET_RESET;
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
      end else begin
         if (squash) begin
            valid <= 1'b0;
         end else if (!stall) begin
            valid <= prev_valid;
         end
         if (!stall) begin
            packet  <= prev_packet;
            mcand   <= prev_mcand << STAGE_BITS;
            mplier  <= prev_mplier >> STAGE_BITS;
            product <= prev_product + partial;
         end
      end
   end

endmodule

// File: rtl/mul_pipe_fu.sv
// Stallable, squashable pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Operands are converted to magnitudes at entry, multiplied over
// NUM_STAGES mul_pipe_stage instances, then sign-corrected and selected.
// Optional build macro MUL_OUT_REG_EN adds a registered output stage
// after the sign/select mux (latency NUM_STAGES+1).
module mul_pipe_fu
   import sys_defs::*;
#(
   parameter int XLEN       = 32,
   parameter int NUM_STAGES = 4,
   parameter int PRF_LEN    = 6,
   parameter int ROB_LEN    = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               squash,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XLEN-1:0]    in_opa,
   input  logic [XLEN-1:0]    in_opb,
   input  ALU_FUNC            in_func,
   input  logic [XLEN-1:0]    in_pc,
   input  logic [PRF_LEN-1:0] in_dest_preg,
   input  logic [ROB_LEN-1:0] in_rob_idx,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_value,
   output logic [PRF_LEN-1:0] out_dest_preg,
   output logic [ROB_LEN-1:0] out_rob_idx,
   output logic [XLEN-1:0]    out_pc
);

   localparam int PW         = 2 * XLEN;
   localparam int STAGE_BITS = PW / NUM_STAGES;

   logic            stall;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   MUL_PACKET       entry_packet;

   logic [NUM_STAGES:0] valid_c;
   MUL_PACKET           packet_c  [0:NUM_STAGES];
   logic [PW-1:0]       mcand_c   [0:NUM_STAGES];
   logic [PW-1:0]       mplier_c  [0:NUM_STAGES];
   logic [PW-1:0]       product_c [0:NUM_STAGES];

   MUL_PACKET       final_packet;
   logic [PW-1:0]   signed_product;
   logic [XLEN-1:0] result;

   // The last stage's shifted operands have no consumer.
   logic unused_tail;
   assign unused_tail = ^{mcand_c[NUM_STAGES], mplier_c[NUM_STAGES]};

   // Backpressure: the whole pipe freezes while a result waits on the CDB.
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   // Sign decode and magnitudes; the most-negative value maps onto itself,
   // which read as unsigned is exactly 2^(XLEN-1).
   always_comb begin
      a_neg = in_opa[XLEN-1] && (in_func inside {ALU_MUL, ALU_MULH, ALU_MULHSU});
      b_neg = in_opb[XLEN-1] && (in_func inside {ALU_MUL, ALU_MULH});
      mag_a = a_neg ? -in_opa : in_opa;
      mag_b = b_neg ? -in_opb : in_opb;
   end

   // Packet entering the first stage.
   always_comb begin
      entry_packet           = MUL_PACKET_RESET;
      entry_packet.pc        = in_pc;
      entry_packet.dest_preg = in_dest_preg;
      entry_packet.rob_idx   = in_rob_idx;
      entry_packet.a_neg     = a_neg;
      entry_packet.b_neg     = b_neg;
      entry_packet.func      = in_func;
   end

   // Stage 0 is the issue port; the stages themselves ignore it while stalled.
   assign valid_c[0]   = in_valid;
   assign packet_c[0]  = entry_packet;
   assign mcand_c[0]   = PW'(mag_a);
   assign mplier_c[0]  = PW'(mag_b);
   assign product_c[0] = '0;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
         mul_pipe_stage #(
            .XLEN       (XLEN),
            .STAGE_BITS (STAGE_BITS)
         ) u_stage (
            .clock        (clock),
            .reset        (reset),
            .squash       (squash),
            .stall        (stall),
            .prev_valid   (valid_c[gi]),
            .prev_packet  (packet_c[gi]),
            .prev_mcand   (mcand_c[gi]),
            .prev_mplier  (mplier_c[gi]),
            .prev_product (product_c[gi]),
            .valid        (valid_c[gi+1]),
            .packet       (packet_c[gi+1]),
            .mcand        (mcand_c[gi+1]),
            .mplier       (mplier_c[gi+1]),
            .product      (product_c[gi+1])
         );
      end
   endgenerate

   // Sign correction of the unsigned product and high/low half selection.
   always_comb begin
      final_packet   = packet_c[NUM_STAGES];
      signed_product = (final_packet.a_neg ^ final_packet.b_neg) ?
                       -product_c[NUM_STAGES] : product_c[NUM_STAGES];
      case (final_packet.func)
         ALU_MUL:                         result = signed_product[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU: result = signed_product[PW-1:XLEN];
         default:                         result = XLEN'(MUL_FALLBACK);
      endcase
   end

`ifdef MUL_OUT_REG_EN
   logic               out_valid_reg;
   logic [XLEN-1:0]    out_value_reg;
   logic [PRF_LEN-1:0] out_dest_preg_reg;
   logic [ROB_LEN-1:0] out_rob_idx_reg;
   logic [XLEN-1:0]    out_pc_reg;

   // Registered output stage; stalls and squashes like the pipe stages.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_reg     <= 1'b0;
         out_value_reg     <= '0;
         out_dest_preg_reg <= '0;
         out_rob_idx_reg   <= '0;
         out_pc_reg        <= '0;
      end else begin
         if (squash) begin
            out_valid_reg <= 1'b0;
         end else if (!stall) begin
            out_valid_reg <= valid_c[NUM_STAGES];
         end
         if (!stall) begin
            out_value_reg     <= result;
            out_dest_preg_reg <= final_packet.dest_preg;
            out_rob_idx_reg   <= final_packet.rob_idx;
            out_pc_reg        <= final_packet.pc;
         end
      end
   end

   assign out_valid     = out_valid_reg;
   assign out_value     = out_value_reg;
   assign out_dest_preg = out_dest_preg_reg;
   assign out_rob_idx   = out_rob_idx_reg;
   assign out_pc        = out_pc_reg;
`else
   assign out_valid     = valid_c[NUM_STAGES];
   assign out_value     = result;
   assign out_dest_preg = final_packet.dest_preg;
   assign out_rob_idx   = final_packet.rob_idx;
   assign out_pc        = final_packet.pc;
`endif

endmodule

// File: tb/tb_mul_pipe_fu.sv
// Self-checking bench for mul_pipe_fu: directed corner ops, back-to-back
// random ops, backpressure, squash, and reset mid-flight, all checked
// every cycle against a latency-queue reference model.
module tb_mul_pipe_fu;
   import sys_defs::*;

   localparam int NS = 4;
`ifdef MUL_OUT_REG_EN
   localparam int LAT = NS + 1;
`else
   localparam int LAT = NS;
`endif

   logic        clock = 1'b0;
   logic        reset, squash, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_opa, in_opb, in_pc, out_value, out_pc;
   ALU_FUNC     in_func;
   logic [5:0]  in_dest_preg, out_dest_preg;
   logic [4:0]  in_rob_idx, out_rob_idx;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] val;
      logic [31:0] pc;
      logic [5:0]  dest;
      logic [4:0]  rob;
      int          age;
   } exp_t;
   exp_t exp_q[$];

   logic        prev_rst = 1'b1;
   logic [4:0]  rob_ctr  = '0;
   ALU_FUNC     funcs [5] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_ADD};
   logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hffffffff, 32'h80000000, 32'h7fffffff};

   mul_pipe_fu #(.XLEN(32), .NUM_STAGES(NS), .PRF_LEN(6), .ROB_LEN(5)) dut (
      .clock         (clock),
      .reset         (reset),
      .squash        (squash),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_opa        (in_opa),
      .in_opb        (in_opb),
      .in_func       (in_func),
      .in_pc         (in_pc),
      .in_dest_preg  (in_dest_preg),
      .in_rob_idx    (in_rob_idx),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_value     (out_value),
      .out_dest_preg (out_dest_preg),
      .out_rob_idx   (out_rob_idx),
      .out_pc        (out_pc)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Architectural result from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_result(ALU_FUNC f, logic [31:0] a, logic [31:0] b);
      longint          sa, sb, ub_s;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa   = $signed(a);
      sb   = $signed(b);
      ua   = {32'h0, a};
      ub   = {32'h0, b};
      ub_s = longint'(ub);
      case (f)
         ALU_MUL:    begin p = sa * sb;   return p[31:0];  end
         ALU_MULH:   begin p = sa * sb;   return p[63:32]; end
         ALU_MULHSU: begin p = sa * ub_s; return p[63:32]; end
         ALU_MULHU:  begin p = ua * ub;   return p[63:32]; end
         default:    return 32'hfacebeec;
      endcase
   endfunction

   // One clock cycle: drive inputs, check outputs against the model,
   // then advance the model to what the coming edge should do.
   task automatic step(input logic rst, input logic sq, input logic iv, input ALU_FUNC f,
                       input logic [31:0] a, input logic [31:0] b, input logic ordy);
      logic exp_valid, stall;
      exp_t e;
      @(negedge clock);
      reset        = rst;
      squash       = sq;
      in_valid     = iv;
      in_func      = f;
      in_opa       = a;
      in_opb       = b;
      in_pc        = $urandom;
      in_dest_preg = 6'($urandom);
      in_rob_idx   = rob_ctr;
      out_ready    = ordy;
      #1;
      exp_valid = (exp_q.size() > 0) && (exp_q[0].age >= LAT);
      stall     = exp_valid && !ordy;
      check("in_ready", in_ready, !stall);
      check("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
         check("out_value", out_value, exp_q[0].val);
         check("out_rob_idx", out_rob_idx, exp_q[0].rob);
         check("out_dest_preg", out_dest_preg, exp_q[0].dest);
         check("out_pc", out_pc, exp_q[0].pc);
      end
      if (prev_rst) begin
         check("reset_value", out_value, 0);
         check("reset_tags", {out_pc, out_dest_preg, out_rob_idx}, 0);
      end
      prev_rst = rst;
      if (rst || sq) begin
         exp_q.delete();
      end else if (!stall) begin
         if (exp_valid) void'(exp_q.pop_front());
         for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            e.age++;
            exp_q[i] = e;
         end
         if (iv) begin
            e.val  = ref_result(f, a, b);
            e.pc   = in_pc;
            e.dest = in_dest_preg;
            e.rob  = in_rob_idx;
            e.age  = 1;
            exp_q.push_back(e);
            rob_ctr++;
         end
      end
   endtask

   function automatic logic [31:0] rand_op();
      if ($urandom_range(0, 1) == 0) return corners[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   task automatic issue_rand(input logic ordy);
      step(1'b0, 1'b0, 1'b1, funcs[$urandom_range(0, 3)], rand_op(), rand_op(), ordy);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, ALU_MUL, 32'h0, 32'h0, 1'b1);
   endtask

   initial begin
      reset = 1'b1; squash = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_opa = '0; in_opb = '0; in_func = ALU_MUL; in_pc = '0;
      in_dest_preg = '0; in_rob_idx = '0;
      repeat (2) @(posedge clock);

      // Directed corner ops, one at a time (exact latency checked by model).
      step(1'b0, 1'b0, 1'b1, ALU_MUL,    32'h7,        32'hfffffffd, 1'b1); idle(LAT + 1);
      step(1'b0, 1'b0, 1'b1, ALU_MULH,   32'h80000000, 32'h80000000, 1'b1); idle(LAT + 1);
      step(1'b0, 1'b0, 1'b1, ALU_MULHU,  32'hffffffff, 32'hffffffff, 1'b1); idle(LAT + 1);
      step(1'b0, 1'b0, 1'b1, ALU_MULHSU, 32'hffffffff, 32'hffffffff, 1'b1); idle(LAT + 1);
      step(1'b0, 1'b0, 1'b1, ALU_ADD,    32'h3,        32'h4,        1'b1); idle(LAT + 1);

      // Back-to-back random ops.
      for (int i = 0; i < 20; i++) issue_rand(1'b1);
      idle(LAT + 1);

      // Backpressure: fill, hold out_ready low 3 cycles with RS still driving.
      for (int i = 0; i < LAT + 2; i++) issue_rand(1'b1);
      for (int i = 0; i < 3; i++) issue_rand(1'b0);
      for (int i = 0; i < 4; i++) issue_rand(1'b1);
      idle(LAT + 1);

      // Squash with 3 ops in flight and a same-cycle issue.
      for (int i = 0; i < 3; i++) issue_rand(1'b1);
      step(1'b0, 1'b1, 1'b1, ALU_MUL, 32'h5, 32'h6, 1'b1);
      idle(LAT + 1);

      // Squash during a stall, then squash on an empty pipe.
      for (int i = 0; i < LAT + 1; i++) issue_rand(1'b1);
      issue_rand(1'b0);
      step(1'b0, 1'b1, 1'b1, ALU_MULH, 32'h9, 32'h9, 1'b0);
      idle(2);
      step(1'b0, 1'b1, 1'b0, ALU_MUL, 32'h0, 32'h0, 1'b1);
      idle(2);

      // Reset mid-flight, then a fresh op.
      for (int i = 0; i < LAT + 1; i++) issue_rand(1'b1);
      step(1'b1, 1'b0, 1'b1, ALU_MUL, 32'h3, 32'h3, 1'b1);
      step(1'b0, 1'b0, 1'b1, ALU_MUL, 32'hfffffffe, 32'h80000001, 1'b1);
      idle(LAT + 1);

      // Random mix of issue, backpressure, squash and reset.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 9) < 7), funcs[$urandom_range(0, 4)],
              rand_op(), rand_op(), ($urandom_range(0, 3) != 0));
      end
      idle(LAT + 2);
      check("drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
